aes_inv_key_sched: RTL

Iterative AES-128 reverse key scheduler for the decryption datapath. It accepts the cipher key and runs the forward schedule internally to reach the round-10 key. It then streams round keys 10, 9, …, 0 in that order over a valid/ready interface, deriving each one by inverting a single expansion step. The inverse cipher consumes keys in exactly this order, so no 11-entry key RAM is needed.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_key_step.sv | 47 ++++
 rtl/sub_byte.sv | 38 +++
 rtl/aes_inv_key_sched.sv | 132 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, state encoding and round-constant table for the AES-128
// inverse key scheduler.
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

    // Round constant for expansion step idx (0..9), placed in byte 3 by the caller.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-expansion step, forward (dir=0) or inverse (dir=1),
// built around a single shared SubWord.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [7:0]       rcon_b,
    input  logic             dir,
    output logic [KEY_W-1:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_src, rot_word, sub_word, t;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] p0, p1, p2, p3;

    assign w0 = key[127:96];
    assign w1 = key[95:64];
    assign w2 = key[63:32];
    assign w3 = key[31:0];

    // Inverse direction first recovers the previous w3 (= w7 ^ w6) to feed SubWord.
    assign sub_src  = dir ? (w3 ^ w2) : w3;
    assign rot_word = {sub_src[23:0], sub_src[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sub_byte u_sub_byte (
            .a (rot_word[8*b +: 8]),
            .y (sub_word[8*b +: 8])
        );
    end

    assign t = sub_word ^ {rcon_b, 24'h000000};

    assign f0 = w0 ^ t;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ t;

    assign key_out = dir ? {p0, p1, p2, p3} : {f0, f1, f2, f3};

endmodule

// File: rtl/sub_byte.sv
// AES S-box for one byte: GF(2^8) inverse (x^254) followed by the affine map.
module sub_byte (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] acc;
        p   = 8'h00;
        acc = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ acc;
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero without special casing.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    assign y = sbox(a);

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 reverse key scheduler: runs the schedule forward, then streams
// round keys 10..0 over valid/ready. Optional key cache: AES_INV_KEY_CACHE_EN.
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
    output logic             done
);

    if (NR != aes_pkg::NR || KEY_W != aes_pkg::KEY_W) begin : g_param_check
        $error("aes_inv_key_sched supports only NR=10 and KEY_W=128");
    end

    state_t           state;
    logic [KEY_W-1:0] key_reg;
    logic [3:0]       ctr;
    logic [KEY_W-1:0] step_in;
    logic [KEY_W-1:0] step_out;
    logic [7:0]       step_rcon;
    logic             step_dir;
    logic             cache_hit;

    // FWD walks key_reg forward; REV walks the presented key backward.
    assign step_dir  = (state == REV);
    assign step_in   = step_dir ? rk_out : key_reg;
    assign step_rcon = step_dir ? rcon(rk_round - 4'd1) : rcon(ctr);
    assign busy      = (state != IDLE);

    aes_key_step u_step (
        .key     (step_in),
        .rcon_b  (step_rcon),
        .dir     (step_dir),
        .key_out (step_out)
    );

`ifdef AES_INV_KEY_CACHE_EN
    logic [KEY_W-1:0] cache_key;
    logic [KEY_W-1:0] cache_rk10;
    logic             cache_valid;

    assign cache_hit = cache_valid && (key_in == cache_key);

    // The key is remembered at start; the pair only becomes valid once FWD finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_key   <= '0;
            cache_rk10  <= '0;
            cache_valid <= 1'b0;
        end else begin
            if (state == IDLE && start && !cache_hit) begin
                cache_key   <= key_in;
                cache_valid <= 1'b0;
            end
            if (state == FWD && ctr == 4'd9) begin
                cache_rk10  <= step_out;
                cache_valid <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_reg  <= '0;
            ctr      <= 4'd0;
            rk_valid <= 1'b0;
            rk_out   <= '0;
            rk_round <= 4'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cache_hit) begin
`ifdef AES_INV_KEY_CACHE_EN
                            rk_out   <= cache_rk10;
`endif
                            rk_round <= 4'(NR);
                            state    <= REV;
                        end else begin
                            key_reg <= key_in;
                            ctr     <= 4'd0;
                            state   <= FWD;
                        end
                    end
                end
                FWD: begin
                    key_reg <= step_out;
                    ctr     <= ctr + 4'd1;
                    if (ctr == 4'(NR - 1)) begin
                        state    <= REV;
                        rk_valid <= 1'b1;
                        rk_round <= 4'(NR);
                        rk_out   <= step_out;
                    end
                end
                REV: begin
                    // A cache hit enters REV with the key loaded but not yet presented.
                    if (!rk_valid) begin
                        rk_valid <= 1'b1;
                    end else if (rk_ready) begin
                        if (rk_round != 4'd0) begin
                            rk_out   <= step_out;
                            rk_round <= rk_round - 4'd1;
                        end else begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
